matrix_key_scan: RTL and testbench
==================================

Name: matrix_key_scan

Overview:
- Scans a 4x4 active-low matrix keypad, debounces it and emits one key code per press.
- Sits directly upstream of the key-press counter. key_vld drives the counter's din_vld input.
- Rows are inputs with pull-ups; columns are driven by this block.

Parameters:
- DEB_CYC, 1000000: consecutive stable cycles needed for press and release debounce (20 ms at 50 MHz).
- SETTLE_CYC, 16: cycles each scan column is held before the rows are sampled; must be >= 3.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEB_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- key_row  in  4  keypad rows, active-low, asynchronous to clk.
- key_col  out  4  column drive, active-low.
- key_num  out  4  code of the last pressed key = row*4 + col.
- key_vld  out  1  one-cycle pulse when key_num is updated.

Behaviour:
- Row synchronisation: key_row passes through a 2-FF synchroniser giving row_s. All decisions use row_s.
- Reset (rst=1 at a clk edge):
  - state=IDLE, debounce and settle counters=0.
  - key_col=4'b0000, key_num=0, key_vld=0.
  - Reset in any state aborts that state immediately. No pulse is emitted.
- IDLE:
  - key_col=0000 (all columns driven).
  - If row_s != 4'hF, go to PRESS_DEB with counter=0.
- PRESS_DEB:
  - key_col=0000.
  - While row_s != F, the counter increments.
  - If row_s == F on any cycle, go back to IDLE with no pulse.
  - When the counter reaches DEB_CYC-1 with row_s still != F, go to SCAN with column index c=0.
- SCAN:
  - key_col = ~(4'b0001 << c), held for SETTLE_CYC cycles.
  - row_s is sampled on the last cycle of that column.
  - If the sample != F: capture r = lowest-index zero bit of the sample, and c. Go to OUT.
  - Otherwise c increments. After c=3 with no hit, go to IDLE (bounce or release mid-scan) with no pulse.
- OUT, one cycle:
  - key_num <= {r[1:0], c[1:0]}; key_vld=1.
  - Next state is REL_DEB.
- REL_DEB:
  - key_col=0000.
  - The counter increments while row_s == F and clears to 0 whenever row_s != F.
  - When it reaches DEB_CYC-1, go to IDLE.
  - A held key therefore produces exactly one pulse. No auto-repeat.
- Multiple keys pressed: the first hit in scan order wins. Lowest column first, then lowest row within that column.
- key_num holds its value between pulses.
- key_vld is 1 only in OUT. Pulses are separated by at least 2*DEB_CYC cycles.
- Latency from a clean press edge on key_row to key_vld: 2 (sync) + 1 + DEB_CYC + (c+1)*SETTLE_CYC + 1 cycles.
- Counter width: the debounce counter is CNT_W bits. It saturates and never wraps.

Decomposition:
- Shared package (key_pkg): state encoding constants IDLE, PRESS_DEB, SCAN, OUT, REL_DEB; constant ROWS=4; constant COLS=4.
- One natural sub-module, sync_2ff: a 4-bit two-flop synchroniser with the same rst. It is reusable across the keypad projects.
- FSM, counters and the priority encoder stay in matrix_key_scan.

Test Plan:
Bench settings for all scenarios: DEB_CYC=8, SETTLE_CYC=4. The bench models the keypad: row r = 0 when col c is driven low and key (r,c) is pressed.
1. Reset checks:
   - rst held for 3 cycles with a key pressed: key_col=0000, key_vld=0, key_num=0 throughout, and no pulse in the cycle after release of rst.
   - rst asserted mid-SCAN: returns to IDLE with no pulse.
2. Clean press of key (2,1) held for 200 cycles:
   - Exactly one key_vld pulse with key_num=9.
   - The pulse arrives 2+1+8+2*4+1 = 20 cycles after the press.
   - key_num stays 9 afterwards.
3. Bounce: key (0,0) toggled every 3 cycles for 30 cycles, then released -> no key_vld; state ends in IDLE.
4. Two keys held, (3,3) and (1,2) -> key_num=6 (column 2 is scanned before column 3).
5. Release debounce, press key 15:
   - Release with one 4-cycle glitch, then press again -> still exactly one pulse until rows have been high for 8 consecutive cycles.
   - The second press then gives a second pulse with key_num=15.
6. Release mid-scan: key pressed through PRESS_DEB, released before its column is scanned -> return to IDLE, no pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the matrix keypad scanner: keypad geometry,
// controller state encoding and the row priority helper.
package key_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    SCAN      = 3'd2,
    OUT       = 3'd3,
    REL_DEB   = 3'd4
  } state_t;

  // Index of the lowest row pulled low; the caller guarantees at least one zero.
  function automatic logic [1:0] first_low(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a small asynchronous bus. Resets to RST_VAL so
// idle inputs with pull-ups do not look active straight after reset.
module sync_2ff
  import key_pkg::*;
#(
  parameter int           W       = ROWS,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops give metastability a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner: debounces a press with all columns driven,
// scans one column at a time to locate the key, emits one code per press and
// then waits for a debounced release before arming again.
module matrix_key_scan
  import key_pkg::*;
#(
  parameter int DEB_CYC    = 1000000,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] key_row,
  output logic [COLS-1:0] key_col,
  output logic [3:0]      key_num,
  output logic            key_vld
);

  localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 2;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [ROWS-1:0]  ROWS_IDLE = '1;

  logic [ROWS-1:0] row_s;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [1:0]       col_q,     col_d;
  logic [COLS-1:0]  key_col_q, key_col_d;
  logic [3:0]       key_num_q, key_num_d;
  logic             key_vld_q, key_vld_d;
  logic [CNT_W-1:0] deb_inc;

  sync_2ff #(
    .W      (ROWS),
    .RST_VAL(ROWS_IDLE)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d  (key_row),
    .q  (row_s)
  );

  // Next-state logic: debounce counters, column walk and the key code capture.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    set_cnt_d = set_cnt_q;
    col_d     = col_q;
    key_num_d = key_num_q;
    deb_inc   = (&deb_cnt_q) ? deb_cnt_q : deb_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        deb_cnt_d = '0;
        set_cnt_d = '0;
        col_d     = 2'd0;
        if (row_s != ROWS_IDLE) state_d = PRESS_DEB;
      end
      PRESS_DEB: begin
        if (row_s == ROWS_IDLE) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          deb_cnt_d = '0;
          set_cnt_d = '0;
          col_d     = 2'd0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      SCAN: begin
        if (set_cnt_q == SET_LAST) begin
          set_cnt_d = '0;
          if (row_s != ROWS_IDLE) begin
            state_d   = OUT;
            key_num_d = {first_low(row_s), col_q};
          end else if (col_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      OUT: begin
        state_d   = REL_DEB;
        deb_cnt_d = '0;
      end
      REL_DEB: begin
        if (row_s != ROWS_IDLE) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
        set_cnt_d = '0;
        col_d     = 2'd0;
      end
    endcase

    key_col_d = (state_d == SCAN) ? ~(COLS'(1) << col_d) : '0;
    key_vld_d = (state_d == OUT);
  end

  // State and registered outputs; reset abandons whatever was in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
      set_cnt_q <= '0;
      col_q     <= 2'd0;
      key_col_q <= '0;
      key_num_q <= 4'd0;
      key_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      set_cnt_q <= set_cnt_d;
      col_q     <= col_d;
      key_col_q <= key_col_d;
      key_num_q <= key_num_d;
      key_vld_q <= key_vld_d;
    end
  end

  assign key_col = key_col_q;
  assign key_num = key_num_q;
  assign key_vld = key_vld_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
// Self-checking bench for matrix_key_scan with a behavioural keypad model.
module tb_matrix_key_scan;

  localparam int DEB   = 8;
  localparam int SET   = 4;
  localparam int BOUND = 80;

  logic        clk;
  logic        rst;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_num;
  logic        key_vld;
  logic [15:0] pressed;

  int compared;
  int mismatched;
  int pulse_cnt;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  matrix_key_scan #(
    .DEB_CYC   (DEB),
    .SETTLE_CYC(SET),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_row(key_row),
    .key_col(key_col),
    .key_num(key_num),
    .key_vld(key_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: row r is pulled low whenever a pressed key (r,c) sits on a low column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      key_row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && key_col[c] === 1'b0) key_row[r] = 1'b0;
      end
    end
  end

  // Reference: the first pressed key in column-major order wins.
  function automatic int refCode(input logic [15:0] mask);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[r*4+c]) return r * 4 + c;
    return 0;
  endfunction

  // Cycles from press to the edge at which the consumer latches key_vld.
  function automatic int refLatency(input int code);
    return 2 + 1 + DEB + ((code % 4) + 1) * SET + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask);
    pressed = mask;
  endtask

  task automatic tick();
    @(negedge clk);
    if (key_vld === 1'b1) pulse_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits for the next pulse; latency counts up to the consuming rising edge.
  task automatic measurePulse(input string name, input logic [3:0] code, input int lat);
    int seen;
    bit found;
    seen  = 0;
    found = 1'b0;
    for (int k = 1; k <= BOUND && !found; k++) begin
      tick();
      if (key_vld === 1'b1) begin
        found = 1'b1;
        seen  = k + 1;
      end
    end
    checkOutput({name, " latency"}, seen, lat);
    checkOutput({name, " key_num"}, {28'd0, key_num}, {28'd0, code});
  endtask

  // One full press/hold/release episode that must yield exactly one pulse.
  task automatic episode(input string name, input logic [15:0] mask,
                         input logic [3:0] code, input int lat, input int hold);
    int base;
    base = pulse_cnt;
    applyStimulus(mask);
    measurePulse(name, code, lat);
    ticks(hold);
    applyStimulus(16'h0000);
    ticks(3 * DEB);
    checkOutput({name, " pulses"}, pulse_cnt - base, 1);
    checkOutput({name, " held num"}, {28'd0, key_num}, {28'd0, code});
  endtask

  initial begin
    int base;
    logic [15:0] m;
    int code;

    compared   = 0;
    mismatched = 0;
    pulse_cnt  = 0;
    pressed    = 16'h0000;
    rst        = 1'b1;

    vecs[0] = '{mask: 16'h0200, code: 4'd9,  lat: 20};
    vecs[1] = '{mask: 16'h8040, code: 4'd6,  lat: 24};
    vecs[2] = '{mask: 16'h0001, code: 4'd0,  lat: 16};
    vecs[3] = '{mask: 16'h1008, code: 4'd12, lat: 16};
    vecs[4] = '{mask: 16'h0880, code: 4'd7,  lat: 28};
    vecs[5] = '{mask: 16'h0144, code: 4'd8,  lat: 16};

    // Reset held with a key down.
    applyStimulus(16'h0020);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset key_col", {28'd0, key_col}, 32'd0);
      checkOutput("reset key_vld", {31'd0, key_vld}, 32'd0);
      checkOutput("reset key_num", {28'd0, key_num}, 32'd0);
    end
    rst = 1'b0;
    tick();
    checkOutput("post-reset key_vld", {31'd0, key_vld}, 32'd0);
    applyStimulus(16'h0000);
    ticks(40);
    checkOutput("reset no pulse", pulse_cnt, 0);

    // Table of clean presses, including the long hold of key (2,1).
    for (int i = 0; i < 6; i++) begin
      episode($sformatf("vec%0d", i), vecs[i].mask, vecs[i].code, vecs[i].lat,
              (i == 0) ? 200 : 40);
    end

    // Bounce on key (0,0): never stable long enough.
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h0001);
      ticks(3);
      applyStimulus(16'h0000);
      ticks(3);
    end
    ticks(40);
    checkOutput("bounce pulses", pulse_cnt - base, 0);
    checkOutput("bounce key_col", {28'd0, key_col}, 32'd0);

    // Release glitch on key 15: short high stretches must not re-arm.
    base = pulse_cnt;
    applyStimulus(16'h8000);
    measurePulse("glitch first", 4'd15, 28);
    ticks(40);
    applyStimulus(16'h0000);
    ticks(6);
    applyStimulus(16'h8000);
    ticks(4);
    applyStimulus(16'h0000);
    ticks(3);
    applyStimulus(16'h8000);
    ticks(40);
    applyStimulus(16'h0000);
    ticks(20);
    checkOutput("glitch single pulse", pulse_cnt - base, 1);
    applyStimulus(16'h8000);
    measurePulse("glitch second", 4'd15, 28);
    ticks(20);
    applyStimulus(16'h0000);
    ticks(3 * DEB);
    checkOutput("glitch total pulses", pulse_cnt - base, 2);

    // Release mid-scan: key (0,3) gone before column 3 is reached.
    base = pulse_cnt;
    applyStimulus(16'h0008);
    ticks(14);
    applyStimulus(16'h0000);
    ticks(60);
    checkOutput("midscan pulses", pulse_cnt - base, 0);
    checkOutput("midscan key_col", {28'd0, key_col}, 32'd0);

    // Reset mid-scan with key 15 held: the scan restarts from scratch.
    base = pulse_cnt;
    applyStimulus(16'h8000);
    ticks(14);
    rst = 1'b1;
    tick();
    checkOutput("rst scan key_col", {28'd0, key_col}, 32'd0);
    checkOutput("rst scan key_vld", {31'd0, key_vld}, 32'd0);
    rst = 1'b0;
    measurePulse("rst scan", 4'd15, 28);
    checkOutput("rst scan pulses", pulse_cnt - base, 1);
    applyStimulus(16'h0000);
    ticks(3 * DEB);

    // Randomized presses of one or two keys against the reference model.
    for (int i = 0; i < 20; i++) begin
      m = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) m = m | (16'h0001 << $urandom_range(0, 15));
      code = refCode(m);
      episode($sformatf("rand%0d", i), m, 4'(code), refLatency(code),
              int'($urandom_range(10, 60)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
